// File: rtl/otp_ctrl_part_seq.sv
// Walks every block of an ECC register partition, either writing a fixed pattern or reading and XOR-folding into a digest.
// Latency: NumBlocks ACCESS cycles with grant tied high, then one DONE cycle; a read ECC fault adds one ERROR cycle.
// Backpressure: req/addr/we held until blk_gnt_i; optional grant timeout under OTP_CTRL_PART_SEQ_TIMEOUT_EN.
module otp_ctrl_part_seq #(
    parameter int NumBlocks     = 16,
    parameter int Width         = 64,
    parameter int TimeoutCycles = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         mode_i,
    input  logic [Width-1:0]             wdata_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         blk_req_o,
    output logic                         blk_we_o,
    output logic [$clog2(NumBlocks)-1:0] blk_addr_o,
    output logic [Width-1:0]             blk_wdata_o,
    input  logic                         blk_gnt_i,
    input  logic [Width-1:0]             blk_rdata_i,
    input  logic                         ecc_err_i,
    output logic [Width-1:0]             digest_o
);

    localparam int AW = $clog2(NumBlocks);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERROR  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q;
    logic [Width-1:0]  wdata_q;
    logic [Width-1:0]  digest_q;
    logic [AW-1:0]     addr_q;
    logic              err_q;
    logic              start_acc;
    logic              gnt_acc;
    logic              last_blk;
    logic              ecc_hit;
    logic              timeout_hit;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign gnt_acc   = (state_q == ST_ACCESS) && blk_gnt_i;
    assign last_blk  = (addr_q == AW'(NumBlocks - 1));
    // ECC status only has meaning for reads; writes never fault on it.
    assign ecc_hit   = gnt_acc && !mode_q && ecc_err_i;

`ifdef OTP_CTRL_PART_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] wait_cnt_q;

    assign timeout_hit = (state_q == ST_ACCESS) && !blk_gnt_i &&
                         (wait_cnt_q == TW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc || gnt_acc) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (ecc_hit || timeout_hit) begin
                    state_d = ST_ERROR;
                end else if (gnt_acc && last_blk) begin
                    state_d = ST_DONE;
                end
            end
            ST_ERROR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= 1'b0;
            wdata_q  <= '0;
            digest_q <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                mode_q   <= mode_i;
                wdata_q  <= wdata_i;
                digest_q <= '0;
                addr_q   <= '0;
                err_q    <= 1'b0;
            end
            if (ecc_hit || timeout_hit) begin
                err_q <= 1'b1;
            end else if (gnt_acc) begin
                if (!mode_q) digest_q <= digest_q ^ blk_rdata_i;
                // Address parks on the last block so it stays in range.
                if (!last_blk) addr_q <= addr_q + AW'(1);
            end
        end
    end

    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        blk_req_o   = (state_q == ST_ACCESS);
        blk_we_o    = (state_q == ST_ACCESS) && mode_q;
        blk_addr_o  = addr_q;
        blk_wdata_o = wdata_q;
        err_o       = err_q;
        digest_o    = digest_q;
    end

endmodule

// File: tb/tb_otp_ctrl_part_seq.sv
// Directed bench for otp_ctrl_part_seq: read, write, ECC fault, ignored restart, mid-pass reset, grant starvation.
module tb_otp_ctrl_part_seq;

    localparam int NB = 16;
    localparam int W  = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          mode_i;
    logic [W-1:0]  wdata_i;
    logic          busy_o, done_o, err_o, blk_req_o, blk_we_o;
    logic [3:0]    blk_addr_o;
    logic [W-1:0]  blk_wdata_o;
    logic          blk_gnt_i;
    logic [W-1:0]  blk_rdata_i;
    logic          ecc_err_i;
    logic [W-1:0]  digest_o;

    always #5 clk_i = ~clk_i;

    otp_ctrl_part_seq #(.NumBlocks(NB), .Width(W), .TimeoutCycles(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .blk_req_o(blk_req_o), .blk_we_o(blk_we_o), .blk_addr_o(blk_addr_o),
        .blk_wdata_o(blk_wdata_o), .blk_gnt_i(blk_gnt_i), .blk_rdata_i(blk_rdata_i),
        .ecc_err_i(ecc_err_i), .digest_o(digest_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Per-pass observations gathered by run_pass.
    int   req_cycles, grants, addr_bad, stable_bad, we_bad, wdata_bad;
    int   done_cycle, done_count, ecc_cycle, first_addr;
    logic post_ecc_req, post_ecc_err, post_ecc_busy;
    logic after_busy, after_done, rst_seen;
    logic [W-1:0] rst_or;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] pat(input int kind, input int i);
        case (kind)
            0:       pat = W'(i);
            1:       pat = 64'h1000 + W'(i);
            default: pat = 64'h1 << i;
        endcase
    endfunction

    task automatic run_pass(input logic mode, input logic [W-1:0] wdat, input int gnt_kind,
                            input int rpat, input int ecc_blk, input int restart_blk,
                            input int rst_blk);
        logic       g, prev_req, prev_gnt, pend_rst;
        logic [3:0] prev_addr;
        int         idx, exp_idx;
        req_cycles = 0; grants = 0; addr_bad = 0; stable_bad = 0; we_bad = 0;
        wdata_bad = 0; done_cycle = -1; done_count = 0; ecc_cycle = -1; first_addr = -1;
        post_ecc_req = 1'bx; post_ecc_err = 1'bx; post_ecc_busy = 1'bx;
        after_busy = 1'bx; after_done = 1'bx; rst_seen = 1'b0; rst_or = 'x;
        @(negedge clk_i);
        start_i = 1'b1; mode_i = mode; wdata_i = wdat; blk_gnt_i = 1'b0; ecc_err_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0; mode_i = ~mode; wdata_i = ~wdat;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0; pend_rst = 1'b0; exp_idx = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (pend_rst) begin
                rst_seen = 1'b1;
                rst_or   = W'({busy_o, done_o, err_o, blk_req_o, blk_we_o}) |
                           W'(blk_addr_o) | blk_wdata_o | digest_o;
                if (done_o) done_count++;
                rst_i = 1'b0;
                break;
            end
            if (done_cycle >= 0 && cyc == done_cycle + 1) begin
                after_busy = busy_o; after_done = done_o;
                break;
            end
            if (done_o) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (ecc_cycle >= 0 && cyc == ecc_cycle + 1) begin
                post_ecc_req = blk_req_o; post_ecc_err = err_o; post_ecc_busy = busy_o;
            end
            if (blk_req_o) begin
                req_cycles++;
                if (first_addr < 0) first_addr = int'(blk_addr_o);
                if (prev_req && !prev_gnt && blk_addr_o !== prev_addr) stable_bad++;
                if (blk_we_o !== mode) we_bad++;
                if (mode && blk_wdata_o !== wdat) wdata_bad++;
            end
            g = (gnt_kind == 0) ? 1'b1 : (gnt_kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            idx = int'(blk_addr_o);
            blk_gnt_i   = g;
            blk_rdata_i = pat(rpat, idx);
            ecc_err_i   = g && (idx == ecc_blk);
            if (g && blk_req_o) begin
                if (idx != exp_idx) addr_bad++;
                exp_idx++;
                grants++;
                if (idx == ecc_blk && ecc_cycle < 0) ecc_cycle = cyc;
            end
            start_i = blk_req_o && (idx == restart_blk);
            if (blk_req_o && idx == rst_blk) begin
                rst_i = 1'b1; pend_rst = 1'b1;
            end
            prev_req = blk_req_o; prev_gnt = g; prev_addr = blk_addr_o;
            @(negedge clk_i);
        end
        blk_gnt_i = 1'b0; ecc_err_i = 1'b0; start_i = 1'b0; rst_i = 1'b0;
    endtask

    initial begin
        int hold_cnt, err_cyc, done_cyc;
        rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; wdata_i = '0;
        blk_gnt_i = 1'b0; blk_rdata_i = '0; ecc_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ctrl", W'({busy_o, done_o, err_o, blk_req_o, blk_we_o}), '0);
        check("rst_addr", W'(blk_addr_o), '0);
        check("rst_data", blk_wdata_o | digest_o, '0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_busy", W'(busy_o), 0);

        // Read pass, grant tied high, rdata = index.
        run_pass(1'b0, '0, 0, 0, -1, -1, -1);
        check("rd_req_cycles", req_cycles, 16);
        check("rd_grants", grants, 16);
        check("rd_addr_seq", addr_bad, 0);
        check("rd_we", we_bad, 0);
        check("rd_done_cycle", done_cycle, 17);
        check("rd_done_count", done_count, 1);
        check("rd_digest", digest_o, 64'h0);
        check("rd_err", W'(err_o), 0);
        check("rd_after_busy", W'({after_busy, after_done}), 0);

        // Write pass, random grant; ECC flag at block 5 must be ignored.
        run_pass(1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 1, 2, 5, -1, -1);
        check("wr_grants", grants, 16);
        check("wr_addr_seq", addr_bad, 0);
        check("wr_stable", stable_bad, 0);
        check("wr_we", we_bad, 0);
        check("wr_wdata", wdata_bad, 0);
        check("wr_err", W'(err_o), 0);
        check("wr_digest", digest_o, 64'h0);
        check("wr_done_count", done_count, 1);

        // Read pass with ECC fault on block 5.
        run_pass(1'b0, '0, 0, 1, 5, -1, -1);
        check("ecc_grants", grants, 6);
        check("ecc_cycle", ecc_cycle, 6);
        check("ecc_post_req", W'(post_ecc_req), 0);
        check("ecc_post_err", W'(post_ecc_err), 1);
        check("ecc_post_busy", W'(post_ecc_busy), 1);
        check("ecc_done_cycle", done_cycle, 8);
        check("ecc_done_count", done_count, 1);
        check("ecc_digest", digest_o, 64'h1004);
        check("ecc_err_held", W'({err_o, busy_o}), 2);

        // Restart pulse (with mode_i=1) during block 3 must be ignored.
        run_pass(1'b0, '0, 1, 2, -1, 3, -1);
        check("rs_grants", grants, 16);
        check("rs_addr_seq", addr_bad, 0);
        check("rs_stable", stable_bad, 0);
        check("rs_we", we_bad, 0);
        check("rs_done_count", done_count, 1);
        check("rs_digest", digest_o, 64'hFFFF);
        check("rs_err", W'(err_o), 0);

        // Reset during block 8, then a fresh pass.
        run_pass(1'b0, '0, 0, 2, -1, -1, 8);
        check("mr_seen", W'(rst_seen), 1);
        check("mr_outputs_zero", rst_or, '0);
        check("mr_no_done", done_count, 0);
        run_pass(1'b0, '0, 0, 2, -1, -1, -1);
        check("mr_first_addr", first_addr, 0);
        check("mr_req_cycles", req_cycles, 16);
        check("mr_digest", digest_o, 64'hFFFF);

        // Grant held low.
        @(negedge clk_i);
        start_i = 1'b1; mode_i = 1'b0; blk_gnt_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
`ifdef OTP_CTRL_PART_SEQ_TIMEOUT_EN
        err_cyc = -1; done_cyc = -1; hold_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (blk_req_o) hold_cnt++;
            if (err_o && err_cyc < 0) err_cyc = c;
            if (done_o && done_cyc < 0) done_cyc = c;
            @(negedge clk_i);
        end
        check("to_req_cycles", hold_cnt, 10);
        check("to_err_cycle", err_cyc, 11);
        check("to_done_cycle", done_cyc, 12);
`else
        hold_cnt = 0; err_cyc = 0; done_cyc = 0;
        for (int c = 1; c <= 1000; c++) begin
            if (blk_req_o && blk_addr_o == 4'd0) hold_cnt++;
            if (err_o) err_cyc++;
            if (done_o) done_cyc++;
            @(negedge clk_i);
        end
        check("hold_req_cycles", hold_cnt, 1000);
        check("hold_no_err", err_cyc, 0);
        check("hold_no_done", done_cyc, 0);
`endif
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("end_idle", W'({busy_o, blk_req_o}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
